// File: rtl/dsp_feed_pkg.sv
// Shared types and constants for the FIR feeder that sequences tap pairs into the hard DSP MAC.
package dsp_feed_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_HOLD  = 2'd3
    } feed_state_e;

    localparam int DEF_NTAPS   = 8;
    localparam int DEF_MAC_LAT = 2;
    // Drain counter only has to count to MAC_LAT-1, and MAC_LAT never exceeds 4.
    localparam int DRN_W       = 2;

    function automatic bit ntaps_ok(input int n);
        return (n >= 2) && (n <= 16) && ((n & (n - 1)) == 0);
    endfunction

    function automatic bit mac_lat_ok(input int l);
        return (l >= 1) && (l <= 4);
    endfunction

endpackage

// File: rtl/dsp_coef_bank.sv
// Coefficient register file: writable only while the feeder is idle, combinational read.
module dsp_coef_bank
    import dsp_feed_pkg::*;
#(
    parameter int NTAPS = DEF_NTAPS,
    parameter int AW    = $clog2(NTAPS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic          idle,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] coef_q [NTAPS];
    logic [31:0] coef_d [NTAPS];

    always_comb begin
        coef_d = coef_q;
        if (we && idle) begin
            coef_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NTAPS; i++) begin
                coef_q[i] <= '0;
            end
        end else begin
            coef_q <= coef_d;
        end
    end

    assign rdata = coef_q[raddr];

endmodule

// File: rtl/dsp_fir_feeder.sv
// N-tap FIR sequencer: keeps the sample history, streams (hist[k], coef[k]) into the DSP MAC
// with ENABLE/CLR framing, then holds the final MAC_OUT behind a valid/ready result port.
module dsp_fir_feeder
    import dsp_feed_pkg::*;
#(
    parameter int NTAPS   = DEF_NTAPS,
    parameter int MAC_LAT = DEF_MAC_LAT,
    parameter int AW      = $clog2(NTAPS)
) (
    input  logic          CLOCK,
    input  logic          RESET_N,
    input  logic          COEF_WE,
    input  logic [AW-1:0] COEF_ADDR,
    input  logic [31:0]   COEF_WDATA,
    input  logic [AW-1:0] NUM_TAPS_M1,
    input  logic          HIST_CLR,
    input  logic [31:0]   SAMPLE_DATA,
    input  logic          SAMPLE_VALID,
    output logic          SAMPLE_READY,
    output logic [31:0]   OPER_DATA,
    output logic [31:0]   COEF_DATA,
    output logic          ENABLE,
    output logic          CLR,
    input  logic [63:0]   MAC_OUT,
    output logic [63:0]   RESULT_DATA,
    output logic          RESULT_VALID,
    input  logic          RESULT_READY,
    output logic          BUSY,
    output logic [1:0]    DBG_STATE
);

    if (!ntaps_ok(NTAPS) || !mac_lat_ok(MAC_LAT)) begin : g_param_err
        $error("dsp_fir_feeder: NTAPS must be a power of two in 2..16 and MAC_LAT in 1..4");
    end

    // Handshakes: a transfer happens on a rising edge where both valid and ready are high;
    // SAMPLE_READY and RESULT_VALID are registered and never depend combinationally on inputs.

    feed_state_e   state_q, state_d;
    logic [AW-1:0] tap_q, tap_d;
    logic [AW-1:0] ntm1_q, ntm1_d;
    logic [DRN_W-1:0] drn_q, drn_d;
    logic [31:0]   hist_q [NTAPS];
    logic [31:0]   hist_d [NTAPS];
    logic [31:0]   oper_q, oper_d;
    logic [31:0]   coefo_q, coefo_d;
    logic          en_q, en_d;
    logic          clr_q, clr_d;
    logic [63:0]   res_q, res_d;
    logic          rv_q, rv_d;
    logic          sr_q, sr_d;
    logic          busy_q, busy_d;

    logic          accept;
    logic [AW-1:0] tap_nx;
    logic [AW-1:0] rd_addr;
    logic [31:0]   rd_coef;

    assign accept  = (state_q == ST_IDLE) && sr_q && SAMPLE_VALID;
    assign tap_nx  = tap_q + AW'(1);
    // Coefficient read address is the tap that will be presented after the coming edge.
    assign rd_addr = accept ? '0 : tap_nx;

    dsp_coef_bank #(
        .NTAPS (NTAPS),
        .AW    (AW)
    ) u_coef_bank (
        .clk   (CLOCK),
        .rst_n (RESET_N),
        .we    (COEF_WE),
        .idle  (state_q == ST_IDLE),
        .waddr (COEF_ADDR),
        .wdata (COEF_WDATA),
        .raddr (rd_addr),
        .rdata (rd_coef)
    );

    always_comb begin
        state_d = state_q;
        tap_d   = tap_q;
        ntm1_d  = ntm1_q;
        drn_d   = drn_q;
        hist_d  = hist_q;
        oper_d  = oper_q;
        coefo_d = coefo_q;
        en_d    = 1'b0;
        clr_d   = 1'b0;
        res_d   = res_q;
        rv_d    = rv_q;
        sr_d    = sr_q;
        busy_d  = busy_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    // A coincident HIST_CLR wipes the old history but the new sample still lands.
                    for (int i = NTAPS - 1; i > 0; i--) begin
                        hist_d[i] = HIST_CLR ? '0 : hist_q[i-1];
                    end
                    hist_d[0] = SAMPLE_DATA;
                    ntm1_d    = NUM_TAPS_M1;
                    tap_d     = '0;
                    oper_d    = SAMPLE_DATA;
                    coefo_d   = rd_coef;
                    en_d      = 1'b1;
                    clr_d     = 1'b1;
                    sr_d      = 1'b0;
                    busy_d    = 1'b1;
                    state_d   = ST_RUN;
                end else if (HIST_CLR) begin
                    for (int i = 0; i < NTAPS; i++) begin
                        hist_d[i] = '0;
                    end
                end
            end
            ST_RUN: begin
                if (tap_q == ntm1_q) begin
                    drn_d   = '0;
                    state_d = ST_DRAIN;
                end else begin
                    tap_d   = tap_nx;
                    oper_d  = hist_q[tap_nx];
                    coefo_d = rd_coef;
                    en_d    = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (drn_q == DRN_W'(MAC_LAT - 1)) begin
                    res_d   = MAC_OUT;
                    rv_d    = 1'b1;
                    state_d = ST_HOLD;
                end else begin
                    drn_d = drn_q + DRN_W'(1);
                end
            end
            ST_HOLD: begin
                if (RESULT_READY) begin
                    rv_d    = 1'b0;
                    sr_d    = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= ST_IDLE;
            tap_q   <= '0;
            ntm1_q  <= '0;
            drn_q   <= '0;
            for (int i = 0; i < NTAPS; i++) begin
                hist_q[i] <= '0;
            end
            oper_q  <= '0;
            coefo_q <= '0;
            en_q    <= 1'b0;
            clr_q   <= 1'b0;
            res_q   <= '0;
            rv_q    <= 1'b0;
            sr_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tap_q   <= tap_d;
            ntm1_q  <= ntm1_d;
            drn_q   <= drn_d;
            hist_q  <= hist_d;
            oper_q  <= oper_d;
            coefo_q <= coefo_d;
            en_q    <= en_d;
            clr_q   <= clr_d;
            res_q   <= res_d;
            rv_q    <= rv_d;
            sr_q    <= sr_d;
            busy_q  <= busy_d;
        end
    end

    assign SAMPLE_READY = sr_q;
    assign OPER_DATA    = oper_q;
    assign COEF_DATA    = coefo_q;
    assign ENABLE       = en_q;
    assign CLR          = clr_q;
    assign RESULT_DATA  = res_q;
    assign RESULT_VALID = rv_q;
    assign BUSY         = busy_q;
    assign DBG_STATE    = state_q;

endmodule
